// File: rtl/esm_instr_feeder_if.sv
// Bundle between the instruction feeder and its environment: program load,
// stream control, and the registered instruction stream toward ESM.
interface esm_instr_feeder_if #(
    parameter int Instruction_word_size = 32,
    parameter int AW                    = 4
);
    logic                             load_en;
    logic [AW-1:0]                    load_addr;
    logic [Instruction_word_size-1:0] load_data;
    logic [AW:0]                      prog_len;
    logic                             start;
    logic                             stall;
    logic [Instruction_word_size-1:0] Instr_out;
    logic                             RegWrite;
    logic                             ALUSrc;
    logic                             valid;
    logic                             done;
    logic [7:0]                       illegal_cnt;

    // master: the feeder itself; slave: whoever loads/starts it and consumes the stream
    modport master (
        input  load_en, load_addr, load_data, prog_len, start, stall,
        output Instr_out, RegWrite, ALUSrc, valid, done, illegal_cnt
    );

    modport slave (
        output load_en, load_addr, load_data, prog_len, start, stall,
        input  Instr_out, RegWrite, ALUSrc, valid, done, illegal_cnt
    );
endinterface

// File: rtl/esm_instr_feeder.sv
// Streams a loadable RV32I program into ESM with decoded RegWrite/ALUSrc,
// terminated by a zero word. Optional macro: ESM_FEEDER_ILLEGAL_SQUASH_EN.
module esm_instr_feeder #(
    parameter int Instruction_word_size = 32,
    parameter int depth                 = 16,
    parameter int AW                    = $clog2(depth)
) (
    input  logic                   clk,
    input  logic                   rst,
    esm_instr_feeder_if.master     bus
);
    localparam logic [Instruction_word_size-1:0] NOP_WORD = Instruction_word_size'(32'h0000_0013);
    localparam logic [AW:0]                      DEPTH_W  = (AW+1)'(depth);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                           state_reg, state_next;
    logic [AW:0]                      pc_reg, pc_next;
    logic [AW:0]                      len_reg, len_next;
    logic [Instruction_word_size-1:0] instr_reg, instr_next;
    logic                             regwrite_reg, regwrite_next;
    logic                             alusrc_reg, alusrc_next;
    logic                             valid_reg, valid_next;
    logic                             done_reg, done_next;
    logic [7:0]                       illegal_cnt_reg, illegal_cnt_next;

    logic [Instruction_word_size-1:0] mem [depth];
    logic [Instruction_word_size-1:0] rd_word;
    logic [2:0]                       dec;
    logic [AW:0]                      len_clamped;

    // Returns {legal, RegWrite, ALUSrc}
    function automatic logic [2:0] decode(input logic [6:0] op);
        case (op)
            7'b0110011: decode = 3'b110;
            7'b0010011: decode = 3'b111;
            7'b0000011: decode = 3'b111;
            7'b0100011: decode = 3'b101;
            7'b1100011: decode = 3'b100;
            7'b0110111: decode = 3'b111;
            7'b0010111: decode = 3'b111;
            7'b1101111: decode = 3'b110;
            7'b1100111: decode = 3'b111;
            default:    decode = 3'b000;
        endcase
    endfunction

    // Program memory is writable only while no stream is in flight
    always_ff @(posedge clk) begin
        if (bus.load_en && state_reg != S_RUN) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign rd_word     = mem[pc_reg[AW-1:0]];
    assign dec         = decode(rd_word[6:0]);
    assign len_clamped = (bus.prog_len > DEPTH_W) ? DEPTH_W : bus.prog_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            pc_reg          <= '0;
            len_reg         <= '0;
            instr_reg       <= '0;
            regwrite_reg    <= 1'b0;
            alusrc_reg      <= 1'b0;
            valid_reg       <= 1'b0;
            done_reg        <= 1'b0;
            illegal_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            len_reg         <= len_next;
            instr_reg       <= instr_next;
            regwrite_reg    <= regwrite_next;
            alusrc_reg      <= alusrc_next;
            valid_reg       <= valid_next;
            done_reg        <= done_next;
            illegal_cnt_reg <= illegal_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        len_next         = len_reg;
        instr_next       = instr_reg;
        regwrite_next    = regwrite_reg;
        alusrc_next      = alusrc_reg;
        valid_next       = valid_reg;
        done_next        = done_reg;
        illegal_cnt_next = illegal_cnt_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    len_next      = len_clamped;
                    pc_next       = '0;
                    instr_next    = '0;
                    regwrite_next = 1'b0;
                    alusrc_next   = 1'b0;
                    valid_next    = 1'b0;
                    done_next     = 1'b0;
                    state_next    = S_RUN;
                end else if (state_reg == S_DONE && !bus.stall) begin
                    // A stalled end-of-stream word stays valid until released
                    instr_next    = '0;
                    regwrite_next = 1'b0;
                    alusrc_next   = 1'b0;
                    valid_next    = 1'b0;
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    valid_next = 1'b1;
                    if (pc_reg < len_reg) begin
                        instr_next    = rd_word;
                        regwrite_next = dec[1];
                        alusrc_next   = dec[0];
                        pc_next       = pc_reg + 1'b1;
`ifdef ESM_FEEDER_ILLEGAL_SQUASH_EN
                        if (!dec[2]) begin
                            instr_next = NOP_WORD;
                            if (illegal_cnt_reg != 8'hFF) begin
                                illegal_cnt_next = illegal_cnt_reg + 8'd1;
                            end
                        end
`endif
                    end else begin
                        instr_next    = '0;
                        regwrite_next = 1'b0;
                        alusrc_next   = 1'b0;
                        done_next     = 1'b1;
                        state_next    = S_DONE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.Instr_out   = instr_reg;
    assign bus.RegWrite    = regwrite_reg;
    assign bus.ALUSrc      = alusrc_reg;
    assign bus.valid       = valid_reg;
    assign bus.done        = done_reg;
    assign bus.illegal_cnt = illegal_cnt_reg;

`ifndef ESM_FEEDER_ILLEGAL_SQUASH_EN
    // Without squashing the NOP constant has no consumer; reference it harmlessly
    logic unused_nop;
    assign unused_nop = ^NOP_WORD;
`endif
endmodule

// File: doc/esm_instr_feeder.md
# esm_instr_feeder

Instruction-stream transmitter that drives the ESM block's `Instr_in`/`RegWrite`/`ALUSrc` inputs. It holds a small loadable program memory and streams one RV32I word per unstalled cycle. Control bits are decoded from each word's opcode, and the stream ends with an all-zero end-of-stream word. It replaces hand-driven stimulus in front of ESM and sits directly upstream of it.

## Interface
Parameters:
- `Instruction_word_size`, 32, instruction width in bits
- `depth`, 16, program memory entries
- `AW`, `$clog2(depth)`, address width (derived)

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `load_en` input 1: write strobe for program memory.
- `load_addr` input AW: write address.
- `load_data` input `Instruction_word_size`: write data.
- `prog_len` input AW+1: number of words to stream; sampled on start.
- `start` input 1: begin streaming.
- `stall` input 1: freeze the stream.
- `Instr_out` output `Instruction_word_size`: registered instruction to ESM `Instr_in`.
- `RegWrite` output 1: registered decode result.
- `ALUSrc` output 1: registered decode result.
- `valid` output 1: `Instr_out` carries a stream word this cycle.
- `done` output 1: stream finished.
- `illegal_cnt` output 8: illegal-opcode count; see Configuration.

## Operation
- States: IDLE, RUN, DONE. Counter `pc` has width AW+1. Latched length `len` = min(`prog_len`, `depth`).
- IDLE, `start`=1: latch `len`, `pc`<=0, go to RUN, `valid`<=0.
- RUN, `stall`=0, `pc`<`len`:
  - `Instr_out`<=mem[`pc`], `valid`<=1, `pc`<=`pc`+1.
  - RegWrite/ALUSrc <= decode(mem[`pc`]).
- RUN, `stall`=0, `pc`==`len`:
  - Emit end-of-stream: `Instr_out`<=0, `valid`<=1, RegWrite<=0, ALUSrc<=0.
  - `done`<=1, go to DONE.
- RUN, `stall`=1: all registers hold, including `valid` and `Instr_out`.
- DONE: `valid`<=0, `Instr_out`<=0, control bits 0, `done` held at 1. `start`=1 behaves as in IDLE and clears `done`.
- `start` in RUN: ignored.
- `load_en` writes mem[`load_addr`] in IDLE or DONE only; ignored in RUN.
- Decode on opcode [6:0] gives (RegWrite, ALUSrc):
  - 0110011 R → (1,0)
  - 0010011 I-ALU → (1,1)
  - 0000011 load → (1,1)
  - 0100011 store → (0,1)
  - 1100011 branch → (0,0)
  - 0110111 LUI → (1,1)
  - 0010111 AUIPC → (1,1)
  - 1101111 JAL → (1,0)
  - 1100111 JALR → (1,1)
  - any other opcode is illegal → (0,0)

## Timing
- Reset values:
  - `Instr_out`=0, RegWrite=0, ALUSrc=0, `valid`=0, `done`=0, `illegal_cnt`=0.
  - `pc`=0, state IDLE.
  - Memory contents are not reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency:
  - `start` sampled at edge k → first word visible after edge k+1.
  - Each further unstalled edge presents the next word.
  - End-of-stream word appears after edge k+1+`len`; `done` rises on that same edge.
- `prog_len`=0: end-of-stream word appears after edge k+1.
- `prog_len`>`depth`: clamped to `depth` words.
- `stall` during the end-of-stream cycle holds the zero word, and `done` stays 1.
- `rst` mid-stream: returns to reset values at the next edge and the stream is abandoned. A new `start` restarts from mem[0].
- `load_en` and `start` in the same IDLE cycle: the write completes at that edge and is visible to the stream.

## Configuration
- `ESM_FEEDER_ILLEGAL_SQUASH_EN` defined:
  - An illegal-opcode word is replaced on `Instr_out` by NOP 0x00000013 with RegWrite=0, ALUSrc=0.
  - `illegal_cnt` increments per emitted illegal word and saturates at 255.
  - The end-of-stream zero word is exempt.
- Not defined:
  - Illegal words pass through unchanged with RegWrite=0, ALUSrc=0.
  - `illegal_cnt` is tied to 0.

## Test plan
- Load mem[0..2] = 0x00A00093, 0x002081B3, 0x00A2E063; `prog_len`=3; pulse `start` at edge k:
  - after edge k+1: 0x00A00093 with (1,1)
  - after edge k+2: 0x002081B3 with (1,0)
  - after edge k+3: 0x00A2E063 with (0,0)
  - after edge k+4: 0x0 with `valid`=1, `done`=1
- Same program, `stall`=1 for 3 cycles after the first word: 0x00A00093 held with `valid`=1 for 4 cycles, then the sequence resumes unchanged.
- `prog_len`=0, `start`: one cycle later, zero word with `valid`=1 and `done`=1; no program words are emitted.
- `prog_len`=20 with `depth`=16: exactly 16 words, then the zero word. `load_en` asserted during RUN leaves memory unchanged (checked by restarting from DONE).
- Assert `rst` after the second word: next cycle all outputs are 0 and the state is IDLE. `start` replays from mem[0].
- mem[0]=0x0000007F with `ESM_FEEDER_ILLEGAL_SQUASH_EN` defined: `Instr_out`=0x00000013, (0,0), `illegal_cnt`=1. Without the macro: `Instr_out`=0x0000007F, (0,0), `illegal_cnt`=0.
